// File: rtl/fsm_pkg.sv
// Shared state definitions for the Moore/Mealy FSM blocks and the pattern generator.
package fsm_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/moore_pattern_gen.sv
// Moore serial pattern transmitter: loads a word on start, shifts it out MSB-first,
// optionally repeats it with a one-cycle gap between frames, then pulses done.
module moore_pattern_gen
    import fsm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int REP_W = 3,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   pattern,
    input  logic [REP_W-1:0]   repeat_cnt,
    output logic               out,
    output logic               valid,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] state,
    output logic [STATE_W-1:0] next_state
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t             cur_state;
    state_t             nxt_state;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   hold;
    logic [IDX_W-1:0]   idx;
    logic [REP_W-1:0]   rep;

    // Next-state decode; reset forces IDLE so the debug view matches the register.
    always_comb begin
        nxt_state = cur_state;
        if (rst) begin
            nxt_state = IDLE;
        end else begin
            case (cur_state)
                IDLE:  if (start) nxt_state = SHIFT;
                SHIFT: if (idx == LAST_IDX) nxt_state = (rep != '0) ? GAP : DONE;
                GAP:   nxt_state = SHIFT;
                DONE:  nxt_state = IDLE;
                default: nxt_state = IDLE;
            endcase
        end
    end

    // State register plus the shift, holding, index and repeat registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= IDLE;
            shreg     <= '0;
            hold      <= '0;
            idx       <= '0;
            rep       <= '0;
        end else begin
            cur_state <= nxt_state;
            case (cur_state)
                IDLE: begin
                    if (start) begin
                        shreg <= pattern;
                        hold  <= pattern;
                        rep   <= repeat_cnt;
                        idx   <= '0;
                    end
                end
                SHIFT: begin
                    shreg <= shreg << 1;
                    idx   <= idx + IDX_W'(1);
                end
                GAP: begin
                    shreg <= hold;
                    idx   <= '0;
                    rep   <= rep - REP_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign out        = (cur_state == SHIFT) ? shreg[WIDTH-1] : 1'b0;
    assign valid      = (cur_state == SHIFT);
    assign done       = (cur_state == DONE);
    assign busy       = (cur_state != IDLE);
    assign state      = cur_state;
    assign next_state = nxt_state;

endmodule

// File: tb/tb_moore_pattern_gen.sv
// Directed self-checking bench for moore_pattern_gen.
module tb_moore_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [2:0] repeat_cnt;
    logic       out;
    logic       valid;
    logic       busy;
    logic       done;
    logic [1:0] state;
    logic [1:0] next_state;

    int total = 0;
    int bad = 0;
    int busyCount, validCount, doneCount, gapCount;
    int firstDone, lastDone;
    logic [95:0] stream;

    moore_pattern_gen #(.WIDTH(8), .REP_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .pattern(pattern),
        .repeat_cnt(repeat_cnt),
        .out(out),
        .valid(valid),
        .busy(busy),
        .done(done),
        .state(state),
        .next_state(next_state)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic sRst, input logic sStart,
                                 input logic [7:0] sPat, input logic [2:0] sRep);
        rst        = sRst;
        start      = sStart;
        pattern    = sPat;
        repeat_cnt = sRep;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_state"}, 32'(state), 32'h0);
        checkOutput({tag, "_out"}, 32'(out), 32'h0);
        checkOutput({tag, "_valid"}, 32'(valid), 32'h0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
        checkOutput({tag, "_done"}, 32'(done), 32'h0);
    endtask

    // Samples the running frame until busy drops; optionally pulses a foreign start.
    task automatic collectFrame(input int maxCycles, input int injectAt);
        busyCount  = 0;
        validCount = 0;
        doneCount  = 0;
        gapCount   = 0;
        stream     = '0;
        for (int i = 0; i < maxCycles; i++) begin
            if (busy) busyCount++;
            if (valid) begin
                validCount++;
                stream = {stream[94:0], out};
            end
            if (done) begin
                doneCount++;
                checkOutput("done_next_idle", 32'(next_state), 32'h0);
            end
            if (state == 2'b10) begin
                gapCount++;
                checkOutput("gap_out", 32'(out), 32'h0);
                checkOutput("gap_valid", 32'(valid), 32'h0);
                checkOutput("gap_next_shift", 32'(next_state), 32'h1);
            end
            if (!busy) break;
            if (i == injectAt) applyStimulus(1'b0, 1'b1, 8'hFF, 3'd7);
            else applyStimulus(1'b0, 1'b0, 8'h00, 3'd0);
        end
        checkOutput("frame_ends", 32'(busy), 32'h0);
    endtask

    initial begin
        // Reset held for two cycles with start asserted.
        applyStimulus(1'b1, 1'b1, 8'hB2, 3'd0);
        checkIdle("rst1");
        checkOutput("rst1_next", 32'(next_state), 32'h0);
        applyStimulus(1'b1, 1'b1, 8'hB2, 3'd0);
        checkIdle("rst2");
        checkOutput("rst2_next", 32'(next_state), 32'h0);
        applyStimulus(1'b0, 1'b0, 8'h00, 3'd0);
        checkIdle("post_rst");

        // Single frame 1011_0010, no repeat.
        applyStimulus(1'b0, 1'b1, 8'hB2, 3'd0);
        checkOutput("single_first_bit", 32'(out), 32'h1);
        checkOutput("single_first_state", 32'(state), 32'h1);
        collectFrame(60, -1);
        checkOutput("single_stream", stream[31:0], 32'h0000_00B2);
        checkOutput("single_valid", 32'(validCount), 32'd8);
        checkOutput("single_busy", 32'(busyCount), 32'd9);
        checkOutput("single_done", 32'(doneCount), 32'd1);
        checkOutput("single_gap", 32'(gapCount), 32'd0);
        checkIdle("single_end");

        // Three bursts of A5 separated by gap cycles.
        applyStimulus(1'b0, 1'b1, 8'hA5, 3'd2);
        collectFrame(100, -1);
        checkOutput("rep_stream", stream[31:0], 32'h00A5_A5A5);
        checkOutput("rep_valid", 32'(validCount), 32'd24);
        checkOutput("rep_busy", 32'(busyCount), 32'd27);
        checkOutput("rep_done", 32'(doneCount), 32'd1);
        checkOutput("rep_gap", 32'(gapCount), 32'd2);
        checkIdle("rep_end");

        // Start with a different word while busy must not disturb the frame.
        applyStimulus(1'b0, 1'b1, 8'hA5, 3'd0);
        collectFrame(60, 3);
        checkOutput("busy_start_stream", stream[31:0], 32'h0000_00A5);
        checkOutput("busy_start_valid", 32'(validCount), 32'd8);
        checkOutput("busy_start_busy", 32'(busyCount), 32'd9);
        checkOutput("busy_start_done", 32'(doneCount), 32'd1);
        checkIdle("busy_start_end");

        // Reset after the fourth bit aborts without a done pulse.
        applyStimulus(1'b0, 1'b1, 8'hB2, 3'd0);
        checkOutput("abort_bit1", 32'(out), 32'h1);
        applyStimulus(1'b0, 1'b0, 8'h00, 3'd0);
        checkOutput("abort_bit2", 32'(out), 32'h0);
        applyStimulus(1'b0, 1'b0, 8'h00, 3'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 3'd0);
        checkOutput("abort_bit4", 32'(out), 32'h1);
        applyStimulus(1'b1, 1'b0, 8'h00, 3'd0);
        checkIdle("abort_rst");
        applyStimulus(1'b0, 1'b0, 8'h00, 3'd0);
        checkIdle("abort_after");
        applyStimulus(1'b0, 1'b1, 8'h81, 3'd0);
        collectFrame(60, -1);
        checkOutput("abort_next_stream", stream[31:0], 32'h0000_0081);
        checkOutput("abort_next_valid", 32'(validCount), 32'd8);
        checkOutput("abort_next_done", 32'(doneCount), 32'd1);

        // Continuous start gives back-to-back frames with one idle cycle between.
        applyStimulus(1'b0, 1'b1, 8'h0F, 3'd0);
        doneCount  = 0;
        validCount = 0;
        stream     = '0;
        firstDone  = -1;
        lastDone   = -1;
        for (int i = 0; i < 30; i++) begin
            if (valid) begin
                validCount++;
                stream = {stream[94:0], out};
            end
            if (done) begin
                doneCount++;
                if (firstDone < 0) firstDone = i;
                lastDone = i;
            end
            if (i == 9) begin
                checkOutput("cont_gap_state", 32'(state), 32'h0);
                checkOutput("cont_gap_busy", 32'(busy), 32'h0);
            end
            if (i < 29) applyStimulus(1'b0, 1'b1, 8'h0F, 3'd0);
        end
        checkOutput("cont_done_count", 32'(doneCount), 32'd3);
        checkOutput("cont_first_done", 32'(firstDone), 32'd8);
        checkOutput("cont_last_done", 32'(lastDone), 32'd28);
        checkOutput("cont_valid", 32'(validCount), 32'd24);
        checkOutput("cont_stream", stream[31:0], 32'h000F_0F0F);
        applyStimulus(1'b0, 1'b0, 8'h00, 3'd0);
        checkIdle("cont_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/moore_pattern_gen.md
Name: moore_pattern_gen

Overview:
- Moore-style serial pattern transmitter. It produces the 1-bit serial `in` stream that the FSM/counter blocks consume, and acts as the sending end of that single-bit interface.
- Loads a parallel pattern word on `start` and shifts it out MSB-first, one bit per clock. The frame can optionally repeat, with a one-cycle gap between frames.
- Exposes `state` and `next_state` for waveform debug, in line with the existing FSM blocks.

Parameters:
- WIDTH, 8, pattern length in bits (2..32).
- REP_W, 3, width of the repeat-count input.
- IDX_W, $clog2(WIDTH), width of the internal bit-index counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request a transmission; sampled only in IDLE.
- pattern  input  WIDTH  word to transmit; captured on the accepted start.
- repeat_cnt  input  REP_W  number of extra repetitions; 0 means send once.
- out  output  1  serial data bit.
- valid  output  1  high while `out` carries a pattern bit.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse in the DONE state.
- state  output  2  current state (debug).
- next_state  output  2  combinational next state (debug).

Behaviour:
- State encoding: IDLE=2'b00, SHIFT=2'b01, GAP=2'b10, DONE=2'b11.
- Reset (rst=1 at an edge):
  - state=IDLE; the shift register, bit index and repeat register are cleared.
  - out=0, valid=0, busy=0, done=0.
  - Reset takes priority over all other inputs.
- Outputs are Moore: they are decoded from the state and the shift register only, never from the inputs.
  - out = shreg[WIDTH-1] in SHIFT, otherwise 0.
  - valid = (state==SHIFT).
  - done = (state==DONE).
  - busy = (state!=IDLE).
- IDLE:
  - If start=1 at edge k: shreg<=pattern, rep<=repeat_cnt, idx<=0, state<=SHIFT.
  - The first bit is visible on `out` after edge k. Latency is 1 cycle from start to first bit.
- SHIFT:
  - At each edge: shreg<=shreg<<1, idx<=idx+1.
  - When idx==WIDTH-1 (last bit):
    - if rep!=0, state<=GAP;
    - else state<=DONE.
- GAP:
  - Lasts exactly 1 cycle, with out=0 and valid=0.
  - At the edge: shreg<=captured pattern copy, idx<=0, rep<=rep-1, state<=SHIFT.
  - A separate pattern holding register retains the original word for these reloads.
- DONE:
  - Lasts 1 cycle, then state<=IDLE unconditionally.
  - A start asserted during DONE is ignored.
- start, pattern and repeat_cnt are ignored in every state other than IDLE. A frame in progress is never altered by input changes.
- Holding start high continuously gives back-to-back transmissions, with one IDLE cycle between DONE and the next SHIFT.
- Frame timing: total busy cycles = WIDTH*(R+1) + R + 1, where R is the captured repeat_cnt.
- rep is decremented only in GAP, so it never underflows.
- Reset mid-frame aborts immediately: no done pulse, and the next start behaves as from cold reset.

Decomposition:
- Shared package `fsm_pkg`:
  - state localparams IDLE, SHIFT, GAP, DONE (2-bit);
  - a STATE_W=2 constant, reused by the existing Moore/Mealy blocks.
- Structure:
  - Single module.
  - The state register and next-state logic stay in the top.
  - Optional sub-module `shift_reg_load`: parallel-load/shift register of WIDTH bits with load/shift enables, reused for the pattern holding copy.

Test Plan:
- Reset hold, rst=1 for 2 cycles with start=1: state=00, next_state=00, out=0, valid=0, busy=0, done=0 throughout.
- Single frame, pattern=8'b1011_0010, repeat_cnt=0, 1-cycle start:
  - out=1,0,1,1,0,0,1,0 on 8 consecutive cycles with valid=1;
  - then done=1 for 1 cycle;
  - busy=1 for exactly 9 cycles;
  - state returns to 00.
- Repeat, pattern=8'hA5, repeat_cnt=2:
  - three 10100101 bursts, each followed by a GAP cycle (state=10, out=0, valid=0) except the last;
  - valid high for 24 cycles, busy high for 27;
  - done pulses once at the end.
- Start while busy: during the frame of 8'hA5, start=1 with pattern=8'hFF on cycle 3. The serial sequence stays 10100101, and only one done pulse occurs.
- Reset mid-SHIFT, asserted after the 4th bit:
  - next cycle state=00, out=0, busy=0, and no done pulse;
  - a following start with pattern=8'h81 yields 10000001 correctly.
- Continuous start=1, pattern=8'h0F, repeat_cnt=0: frames 00001111 repeat, with DONE then one IDLE cycle between them; done pulses every 10 cycles.
